// File: rtl/controller_dram_tester.sv
// controller_dram_tester
//   Avalon-MM initiator for bring-up and scrubbing of the on-chip 512x32
//   single-port RAM. In FILL mode it writes a deterministic pattern over a
//   wrapping address range. In VERIFY mode it reads the range back, compares
//   each word with the regenerated pattern, and counts the mismatches.
//
//   Build option:
//     CONTROLLER_DRAM_TESTER_LFSR_EN  pattern advances as a 32-bit Galois LFSR
//                                     (taps 0xA3000000, seed 0 forced to 1);
//                                     when undefined the pattern increments.
//
//   Ports
//     clk, reset_n        clock (rising edge), async active-low reset
//     start, mode         command strobe (IDLE only), 0 = FILL / 1 = VERIFY
//     start_addr, length  first word address, word count 0..2**ADDR_W
//     seed                pattern value of the first word
//     abort               cancels the running operation (no done pulse)
//     busy, done          operation in progress, 1-cycle completion pulse
//     err_count, err_flag VERIFY mismatch count and its non-zero flag
//     first_err_addr      address of the first VERIFY mismatch
//     avm_*               Avalon-MM master towards the RAM slave port
//                         (read latency 1, no waitrequest)
module controller_dram_tester #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [LEN_W-1:0]      length,
  input  logic [DATA_W-1:0]     seed,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic                  err_flag,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_write,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic                  avm_clken,
  input  logic [DATA_W-1:0]     avm_readdata
);

  localparam logic [LEN_W-1:0] ERR_MAX = LEN_W'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

`ifdef CONTROLLER_DRAM_TESTER_LFSR_EN
  localparam logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(32'hA300_0000);

  // An all-zero LFSR state would lock up, so a zero seed starts at 1.
  function automatic logic [DATA_W-1:0] seed_init(input logic [DATA_W-1:0] s);
    seed_init = (s == '0) ? DATA_W'(1) : s;
  endfunction

  function automatic logic [DATA_W-1:0] next_pat(input logic [DATA_W-1:0] p);
    next_pat = (p >> 1) ^ (p[0] ? LFSR_TAPS : '0);
  endfunction
`else
  function automatic logic [DATA_W-1:0] seed_init(input logic [DATA_W-1:0] s);
    seed_init = s;
  endfunction

  function automatic logic [DATA_W-1:0] next_pat(input logic [DATA_W-1:0] p);
    next_pat = p + DATA_W'(1);
  endfunction
`endif

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] pat_q;
  logic [LEN_W-1:0]  remain_q;   // words still to be issued on the bus
  logic              accept;
  logic              issue;
  logic              mismatch;

  // Read-return stage: expected word and its address, one cycle behind the read
  logic              vld_p1;
  logic [DATA_W-1:0] exp_p1;
  logic [ADDR_W-1:0] addr_p1;

  assign accept   = (state == S_IDLE) && start && !abort;
  assign issue    = ((state == S_WRITE) || (state == S_READ)) && !abort;
  assign mismatch = vld_p1 && (avm_readdata != exp_p1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (length == '0)  state_nxt = S_DONE;
          else if (mode)     state_nxt = S_READ;
          else               state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (abort)                       state_nxt = S_IDLE;
        else if (remain_q == LEN_W'(1))  state_nxt = S_DONE;
      end
      S_READ: begin
        if (abort)                       state_nxt = S_IDLE;
        else if (remain_q == LEN_W'(1))  state_nxt = S_DRAIN;
      end
      // DRAIN issues nothing; it only lets the last read word be compared
      S_DRAIN: state_nxt = abort ? S_IDLE : S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Issue stage: FSM, address/pattern generators, result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      addr_q         <= '0;
      pat_q          <= '0;
      remain_q       <= '0;
      vld_p1         <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state  <= state_nxt;
      // A read issued in an abort cycle is abandoned, so its data is not compared
      vld_p1 <= (state == S_READ) && !abort;
      if (accept) begin
        addr_q         <= start_addr;
        pat_q          <= seed_init(seed);
        remain_q       <= length;
        err_count      <= '0;
        first_err_addr <= '0;
      end else begin
        if (issue) begin
          addr_q   <= addr_q + ADDR_W'(1);
          pat_q    <= next_pat(pat_q);
          remain_q <= remain_q - LEN_W'(1);
        end
        if (mismatch) begin
          if (err_count != ERR_MAX) err_count <= err_count + LEN_W'(1);
          if (err_count == '0)      first_err_addr <= addr_p1;
        end
      end
    end
  end

  // Return stage: data registers carry no reset, their validity is vld_p1
  always_ff @(posedge clk) begin
    exp_p1  <= pat_q;
    addr_p1 <= addr_q;
  end

  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);
  assign err_flag       = (err_count != '0);
  assign avm_address    = addr_q;
  assign avm_chipselect = (state == S_WRITE) || (state == S_READ);
  assign avm_write      = (state == S_WRITE);
  assign avm_byteenable = '1;
  assign avm_writedata  = pat_q;
  assign avm_clken      = 1'b1;

endmodule
